// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle shared by the pipeline write-back stage,
// the MDU result path and the write-port arbiter.
interface wb_port_arbiter_if;
   logic        pipe_valid;
   logic [4:0]  pipe_rd;
   logic [1:0]  pipe_sel;
   logic        pipe_stall;
   logic        mdu_valid;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_data;
   logic        mdu_ready;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [1:0]  wb_sel;
   logic        wb_src_mdu;
   logic [31:0] mdu_wdata;
   logic [1:0]  pend_count;

   modport master (
      input  pipe_valid, pipe_rd, pipe_sel, mdu_valid, mdu_rd, mdu_data,
      output pipe_stall, mdu_ready, rf_we, rf_rd, wb_sel, wb_src_mdu,
             mdu_wdata, pend_count
   );

   modport slave (
      output pipe_valid, pipe_rd, pipe_sel, mdu_valid, mdu_rd, mdu_data,
      input  pipe_stall, mdu_ready, rf_we, rf_rd, wb_sel, wb_src_mdu,
             mdu_wdata, pend_count
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back vs. buffered MDU
// results, with starvation stalls and WAW kill of stale MDU results.
module wb_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   wb_port_arbiter_if.master  bus
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef struct packed {
      logic        live;
      logic [4:0]  rd;
      logic [31:0] data;
   } entry_t;

   entry_t [1:0] fifo_q;
   logic         rd_ptr_q;
   logic         wr_ptr_q;
   logic [1:0]   occ_q;
   logic [3:0]   starve_q;

   logic         rf_we_q;
   logic [4:0]   rf_rd_q;
   logic [1:0]   wb_sel_q;
   logic         src_mdu_q;
   logic [31:0]  wdata_q;

   entry_t       head;
   logic         head_valid;
   logic         head_live;
   logic         head_dead;
   logic         stall;
   logic         ready;
   logic         grant_pipe;
   logic         grant_mdu;
   logic         pop;
   logic         store;
   logic [3:0]   starve_d;

   always_comb begin
      stall      = (starve_q == LIMIT);
      ready      = (occ_q != 2'd2);
      head       = fifo_q[rd_ptr_q];
      head_valid = (occ_q != 2'd0);
      head_live  = head_valid && head.live;
      head_dead  = head_valid && !head.live;
      // A dead head is discarded without using the port, so the pipe may still write.
      grant_pipe = bus.pipe_valid && (bus.pipe_rd != '0) && !stall;
      grant_mdu  = !grant_pipe && head_live;
      pop        = head_dead || grant_mdu;
      store      = bus.mdu_valid && ready && (bus.mdu_rd != '0) &&
                   !(grant_pipe && (bus.pipe_rd == bus.mdu_rd));
   end

   always_comb begin
      starve_d = starve_q;
      if (!head_valid || pop)
         starve_d = '0;
      else if (head_live && (starve_q != LIMIT))
         starve_d = starve_q + 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_q    <= '0;
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         occ_q     <= '0;
         starve_q  <= '0;
         rf_we_q   <= 1'b0;
         rf_rd_q   <= '0;
         wb_sel_q  <= '0;
         src_mdu_q <= 1'b0;
         wdata_q   <= '0;
      end else begin
         // The pipe write is younger than anything buffered, so same-rd entries go stale.
         for (int unsigned i = 0; i < 2; i++) begin
            if (grant_pipe && (fifo_q[1'(i)].rd == bus.pipe_rd))
               fifo_q[1'(i)].live <= 1'b0;
         end
         if (pop) begin
            fifo_q[rd_ptr_q].live <= 1'b0;
            rd_ptr_q              <= ~rd_ptr_q;
         end
         if (store) begin
            fifo_q[wr_ptr_q] <= {1'b1, bus.mdu_rd, bus.mdu_data};
            wr_ptr_q         <= ~wr_ptr_q;
         end
         occ_q    <= occ_q + {1'b0, store} - {1'b0, pop};
         starve_q <= starve_d;

         rf_we_q <= grant_pipe || grant_mdu;
         if (grant_pipe) begin
            rf_rd_q   <= bus.pipe_rd;
            wb_sel_q  <= bus.pipe_sel;
            src_mdu_q <= 1'b0;
         end else if (grant_mdu) begin
            rf_rd_q   <= head.rd;
            wdata_q   <= head.data;
            src_mdu_q <= 1'b1;
         end
      end
   end

   always_comb begin
      bus.pipe_stall = stall;
      bus.mdu_ready  = ready;
      bus.rf_we      = rf_we_q;
      bus.rf_rd      = rf_rd_q;
      bus.wb_sel     = wb_sel_q;
      bus.wb_src_mdu = src_mdu_q;
      bus.mdu_wdata  = wdata_q;
      bus.pend_count = {1'b0, fifo_q[0].live} + {1'b0, fifo_q[1].live};
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a queue-based behavioural model
// predicts every cycle's outputs into a scoreboard, plus directed scenarios.
module tb_wb_port_arbiter;

   localparam int unsigned LIMIT = 4;

   logic clk;
   logic rst_n;
   wb_port_arbiter_if bus ();

   wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit        live;
      bit [4:0]  rd;
      bit [31:0] data;
   } ment_t;

   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [1:0]  sel;
      logic        src;
      logic [31:0] wdata;
      logic [1:0]  pend;
      logic        ready;
      logic        stall;
   } outs_t;

   ment_t          mq[$];
   int unsigned    m_starve;
   outs_t          m_out;
   outs_t          sb[$];
   outs_t          obs;
   logic [36:0]    wlog[$];

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      sb.delete();
      m_starve = 0;
      m_out    = '0;
      m_out.ready = 1'b1;
   endtask

   // Drive one cycle of stimulus, predict the post-edge outputs, then compare.
   task automatic cycle(input logic pv, input logic [4:0] prd, input logic [1:0] psel,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        output logic pipe_took, output logic mdu_took);
      bit    s_stall, s_ready, hl, hd, gp, gm;
      int unsigned live_n;
      outs_t e;
      outs_t got;

      bus.pipe_valid = pv;
      bus.pipe_rd    = prd;
      bus.pipe_sel   = psel;
      bus.mdu_valid  = mv;
      bus.mdu_rd     = mrd;
      bus.mdu_data   = md;

      s_stall = (m_starve == LIMIT);
      s_ready = (mq.size() < 2);
      hl = (mq.size() != 0) && mq[0].live;
      hd = (mq.size() != 0) && !mq[0].live;
      gp = pv && (prd != 0) && !s_stall;
      gm = !gp && hl;

      e = m_out;
      e.we = gp || gm;
      if (gp) begin
         e.rd  = prd;
         e.sel = psel;
         e.src = 1'b0;
      end else if (gm) begin
         e.rd    = mq[0].rd;
         e.wdata = mq[0].data;
         e.src   = 1'b1;
      end

      if (mq.size() == 0 || hd || gm) m_starve = 0;
      else if (m_starve < LIMIT)      m_starve++;

      if (hd || gm) void'(mq.pop_front());
      if (gp) foreach (mq[i]) if (mq[i].rd == prd) mq[i].live = 1'b0;
      if (mv && s_ready && mrd != 0 && !(gp && prd == mrd))
         mq.push_back('{live: 1'b1, rd: mrd, data: md});

      live_n = 0;
      foreach (mq[i]) if (mq[i].live) live_n++;
      e.pend  = 2'(live_n);
      e.ready = (mq.size() < 2);
      e.stall = (m_starve == LIMIT);
      m_out = e;
      sb.push_back(e);

      pipe_took = !pv || !s_stall;
      mdu_took  = !mv || s_ready;

      @(posedge clk);
      #1;
      got = {bus.rf_we, bus.rf_rd, bus.wb_sel, bus.wb_src_mdu, bus.mdu_wdata,
             bus.pend_count, bus.mdu_ready, bus.pipe_stall};
      obs = got;
      if (got.we === 1'b1 && got.src === 1'b1) wlog.push_back({got.rd, got.wdata});

      if (sb.size() == 0) begin
         check_eq("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check_eq("rf_we",      32'(got.we),    32'(e.we));
         check_eq("rf_rd",      32'(got.rd),    32'(e.rd));
         check_eq("wb_sel",     32'(got.sel),   32'(e.sel));
         check_eq("wb_src_mdu", 32'(got.src),   32'(e.src));
         check_eq("mdu_wdata",  got.wdata,      e.wdata);
         check_eq("pend_count", 32'(got.pend),  32'(e.pend));
         check_eq("mdu_ready",  32'(got.ready), 32'(e.ready));
         check_eq("pipe_stall", 32'(got.stall), 32'(e.stall));
      end
   endtask

   function automatic logic [4:0] next_rd(input logic [4:0] r, input logic [4:0] lo, input logic [4:0] hi);
      return (r >= hi) ? lo : r + 5'd1;
   endfunction

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic        pt, mt;
      logic [4:0]  prd, held;
      int          stall_at, held_cycles;
      logic        rpv, rmv, need_p, need_m;
      logic [4:0]  rprd, rmrd;
      logic [1:0]  rpsel;
      logic [31:0] rmd;

      bus.pipe_valid = 1'b0; bus.pipe_rd = '0; bus.pipe_sel = '0;
      bus.mdu_valid  = 1'b0; bus.mdu_rd  = '0; bus.mdu_data = '0;
      model_reset();
      rst_n = 1'b0;
      #2;
      check_eq("rst_rf_we",  32'(bus.rf_we),      32'd0);
      check_eq("rst_ready",  32'(bus.mdu_ready),  32'd1);
      check_eq("rst_stall",  32'(bus.pipe_stall), 32'd0);
      check_eq("rst_pend",   32'(bus.pend_count), 32'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Idle pipe: buffered MDU result is written on the next free cycle.
      cycle(0, 5'd0, 2'd0, 1, 5'd5, 32'hDEADBEEF, pt, mt);
      check_eq("idle_pend1", 32'(obs.pend), 32'd1);
      cycle(0, 5'd0, 2'd0, 0, 5'd0, 32'd0, pt, mt);
      check_eq("idle_we",    32'(obs.we),  32'd1);
      check_eq("idle_rd",    32'(obs.rd),  32'd5);
      check_eq("idle_src",   32'(obs.src), 32'd1);
      check_eq("idle_wdata", obs.wdata,    32'hDEADBEEF);
      repeat (2) cycle(0, 5'd0, 2'd0, 0, 5'd0, 32'd0, pt, mt);

      // Starvation: continuous pipe traffic forces a one-cycle stall.
      prd = 5'd1;
      cycle(1, prd, 2'd1, 1, 5'd20, 32'h2020_2020, pt, mt);
      if (pt) prd = next_rd(prd, 5'd1, 5'd9);
      stall_at = 0;
      for (int k = 1; k <= 12 && stall_at == 0; k++) begin
         cycle(1, prd, 2'd1, 0, 5'd0, 32'd0, pt, mt);
         if (obs.stall === 1'b1) stall_at = k;
         if (pt) prd = next_rd(prd, 5'd1, 5'd9);
      end
      check_eq("starve_delay", 32'(stall_at), 32'(LIMIT));
      held = prd;
      cycle(1, prd, 2'd1, 0, 5'd0, 32'd0, pt, mt);
      check_eq("starve_took", 32'(pt), 32'd0);
      check_eq("starve_src",  32'(obs.src), 32'd1);
      check_eq("starve_rd",   32'(obs.rd),  32'd20);
      check_eq("starve_end",  32'(obs.stall), 32'd0);
      cycle(1, prd, 2'd1, 0, 5'd0, 32'd0, pt, mt);
      check_eq("resume_src", 32'(obs.src), 32'd0);
      check_eq("resume_rd",  32'(obs.rd),  32'(held));
      repeat (2) cycle(0, 5'd0, 2'd0, 0, 5'd0, 32'd0, pt, mt);

      // Full FIFO: third result is held until a slot frees, order preserved.
      wlog.delete();
      prd = 5'd10;
      cycle(1, prd, 2'd0, 1, 5'd3, 32'h0000_0033, pt, mt);
      if (pt) prd = next_rd(prd, 5'd10, 5'd15);
      cycle(1, prd, 2'd0, 1, 5'd4, 32'h0000_0044, pt, mt);
      if (pt) prd = next_rd(prd, 5'd10, 5'd15);
      check_eq("full_ready", 32'(obs.ready), 32'd0);
      check_eq("full_pend",  32'(obs.pend),  32'd2);
      held_cycles = 0;
      mt = 1'b0;
      for (int k = 0; k < 20 && !mt; k++) begin
         cycle(1, prd, 2'd0, 1, 5'd6, 32'h0000_0066, pt, mt);
         if (pt) prd = next_rd(prd, 5'd10, 5'd15);
         if (!mt) held_cycles++;
      end
      check_eq("full_accepted", 32'(mt), 32'd1);
      check_eq("full_held", 32'(held_cycles > 0), 32'd1);
      repeat (6) cycle(0, 5'd0, 2'd0, 0, 5'd0, 32'd0, pt, mt);
      check_eq("full_nwr", 32'(wlog.size()), 32'd3);
      if (wlog.size() == 3) begin
         check_eq("full_wr0", 32'(wlog[0]), 32'({5'd3, 32'h33}));
         check_eq("full_wr1", 32'(wlog[1]), 32'({5'd4, 32'h44}));
         check_eq("full_wr2", 32'(wlog[2]), 32'({5'd6, 32'h66}));
      end

      // WAW kill: younger pipe write to rd=7 kills the buffered result.
      wlog.delete();
      cycle(1, 5'd1, 2'd1, 1, 5'd7, 32'h7777_7777, pt, mt);
      check_eq("waw_pend1", 32'(obs.pend), 32'd1);
      cycle(1, 5'd7, 2'd2, 0, 5'd0, 32'd0, pt, mt);
      check_eq("waw_we",    32'(obs.we),   32'd1);
      check_eq("waw_rd",    32'(obs.rd),   32'd7);
      check_eq("waw_sel",   32'(obs.sel),  32'd2);
      check_eq("waw_src",   32'(obs.src),  32'd0);
      check_eq("waw_pend0", 32'(obs.pend), 32'd0);
      repeat (4) cycle(0, 5'd0, 2'd0, 0, 5'd0, 32'd0, pt, mt);
      check_eq("waw_no_mdu_wr", 32'(wlog.size()), 32'd0);

      // rd=0 on both sources never uses the port.
      cycle(1, 5'd0, 2'd1, 1, 5'd0, 32'h1234_5678, pt, mt);
      check_eq("rd0_we",   32'(obs.we),   32'd0);
      check_eq("rd0_pend", 32'(obs.pend), 32'd0);
      cycle(0, 5'd0, 2'd0, 0, 5'd0, 32'd0, pt, mt);
      check_eq("rd0_we2",  32'(obs.we),   32'd0);

      // Random traffic with small rd range to provoke WAW kills and stalls.
      need_p = 1'b1; need_m = 1'b1;
      rpv = 0; rprd = '0; rpsel = '0; rmv = 0; rmrd = '0; rmd = '0;
      for (int n = 0; n < 400; n++) begin
         if (need_p) begin
            rpv   = ($urandom_range(0, 3) != 0);
            rprd  = 5'($urandom_range(0, 7));
            rpsel = 2'($urandom_range(0, 3));
         end
         if (need_m) begin
            rmv  = ($urandom_range(0, 2) == 0);
            rmrd = 5'($urandom_range(0, 7));
            rmd  = $urandom;
         end
         cycle(rpv, rprd, rpsel, rmv, rmrd, rmd, pt, mt);
         need_p = pt;
         need_m = mt;
      end
      repeat (6) cycle(0, 5'd0, 2'd0, 0, 5'd0, 32'd0, pt, mt);

      // Mid-operation reset with two buffered entries.
      cycle(1, 5'd1, 2'd1, 1, 5'd21, 32'h2121_2121, pt, mt);
      cycle(1, 5'd2, 2'd3, 1, 5'd22, 32'h2222_2222, pt, mt);
      check_eq("pre_rst_pend", 32'(obs.pend), 32'd2);
      check_eq("pre_rst_we",   32'(obs.we),   32'd1);
      bus.pipe_valid = 1'b0;
      bus.mdu_valid  = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_we",    32'(bus.rf_we),      32'd0);
      check_eq("arst_rd",    32'(bus.rf_rd),      32'd0);
      check_eq("arst_sel",   32'(bus.wb_sel),     32'd0);
      check_eq("arst_src",   32'(bus.wb_src_mdu), 32'd0);
      check_eq("arst_wdata", bus.mdu_wdata,       32'd0);
      check_eq("arst_pend",  32'(bus.pend_count), 32'd0);
      check_eq("arst_stall", 32'(bus.pipe_stall), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("post_rst_ready", 32'(bus.mdu_ready),  32'd1);
      check_eq("post_rst_pend",  32'(bus.pend_count), 32'd0);
      wlog.delete();
      repeat (3) cycle(0, 5'd0, 2'd0, 0, 5'd0, 32'd0, pt, mt);
      check_eq("post_rst_no_wr", 32'(wlog.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
